// File: rtl/cordic_scheduler_pkg.sv
// Shared definitions for the CORDIC frame scheduler.
//
// Contents:
//   state_t  - FSM state encoding for cordic_scheduler
//   StIdle   - waiting for a frame; the only state that accepts input
//   StRun    - issuing words to the CORDIC and collecting its results
//   StDone   - one-cycle completion state; data_out updated, valid_out pulsed
package cordic_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

endpackage

// File: rtl/cordic_scheduler.sv
// Time-multiplexes one shared CORDIC across CHANNELS rectangular words per frame.
// A frame is latched on accept, its words are streamed to the CORDIC one per
// handshake, and results are gathered in order as they return (concurrently
// with issue). When the last result lands, the whole polar frame is published
// on data_out together with a single-cycle valid_out pulse.
//
// Ports:
//   clk_in               - clock, rising edge
//   rst_in               - synchronous active-high reset
//   data_in              - packed frame, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
//   valid_in / ready_out - frame handshake; ready_out only in IDLE
//   data_out             - polar results per channel, held until next completion
//   valid_out            - one-cycle pulse when data_out is refreshed
//   cordic_tdata_out     - word to the CORDIC cartesian input
//   cordic_tvalid_out    - CORDIC input valid
//   cordic_tready_in     - CORDIC input ready
//   cordic_dout_in       - CORDIC result word
//   cordic_dout_valid_in - CORDIC result valid (no backpressure)
//   cordic_aresetn_out   - CORDIC reset, the inverse of rst_in
//   busy_out             - high whenever not IDLE
//   error_out            - sticky: a CORDIC result arrived outside RUN
module cordic_scheduler
    import cordic_scheduler_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic signed [DATA_WIDTH-1:0] data_out [CHANNELS],
    output logic                         valid_out,
    output logic [DATA_WIDTH-1:0]        cordic_tdata_out,
    output logic                         cordic_tvalid_out,
    input  logic                         cordic_tready_in,
    input  logic [DATA_WIDTH-1:0]        cordic_dout_in,
    input  logic                         cordic_dout_valid_in,
    output logic                         cordic_aresetn_out,
    output logic                         busy_out,
    output logic                         error_out
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             issue_idx_q, issue_idx_d;
    logic [IDX_W-1:0]             ret_idx_q, ret_idx_d;
    logic                         issue_done_q, issue_done_d;
    logic                         valid_q;
    logic                         error_q;
    logic [DATA_WIDTH-1:0]        frame_q  [CHANNELS];
    logic [DATA_WIDTH-1:0]        result_q [CHANNELS];
    logic signed [DATA_WIDTH-1:0] out_q    [CHANNELS];

    logic accept;
    logic issue_fire;
    logic ret_fire;
    logic ret_last;
    logic stray;

    always_comb begin
        accept     = (state_q == StIdle) && valid_in;
        issue_fire = cordic_tvalid_out && cordic_tready_in;
        ret_fire   = (state_q == StRun) && cordic_dout_valid_in;
        ret_last   = ret_fire && (ret_idx_q == LAST_IDX);
        // A result outside RUN has no slot to land in; it is only flagged.
        stray      = (state_q != StRun) && cordic_dout_valid_in;
    end

    assign ready_out          = (state_q == StIdle);
    assign busy_out           = (state_q != StIdle);
    assign cordic_tvalid_out  = (state_q == StRun) && !issue_done_q;
    assign cordic_tdata_out   = frame_q[issue_idx_q];
    assign cordic_aresetn_out = ~rst_in;
    assign valid_out          = valid_q;
    assign error_out          = error_q;
    assign data_out           = out_q;

    always_comb begin
        state_d      = state_q;
        issue_idx_d  = issue_idx_q;
        ret_idx_d    = ret_idx_q;
        issue_done_d = issue_done_q;
        case (state_q)
            StIdle: begin
                if (valid_in) begin
                    state_d      = StRun;
                    issue_idx_d  = '0;
                    ret_idx_d    = '0;
                    issue_done_d = 1'b0;
                end
            end
            StRun: begin
                // Indices stop at the last slot instead of wrapping, so the
                // final values stay meaningful while DONE is visible.
                if (issue_fire) begin
                    if (issue_idx_q == LAST_IDX) begin
                        issue_done_d = 1'b1;
                    end else begin
                        issue_idx_d = issue_idx_q + 1'b1;
                    end
                end
                // Results never precede their issue, so the last result also
                // implies issue is complete.
                if (ret_fire) begin
                    if (ret_idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        ret_idx_d = ret_idx_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            issue_idx_q  <= '0;
            ret_idx_q    <= '0;
            issue_done_q <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            ret_idx_q    <= ret_idx_d;
            issue_done_q <= issue_done_d;
            // Output copy happens on the edge into DONE so data_out and the
            // valid_out pulse are both visible during the DONE cycle.
            valid_q      <= ret_last;
            if (stray) begin
                error_q <= 1'b1;
            end
            if (ret_last) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    out_q[i] <= (i == CHANNELS - 1) ? $signed(cordic_dout_in)
                                                    : $signed(result_q[i]);
                end
            end
        end
    end

    // Frame and result buffers are pure data paths; their contents are only
    // consumed under control that is itself reset.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int i = 0; i < CHANNELS; i++) begin
                frame_q[i] <= data_in[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
        if (ret_fire) begin
            result_q[ret_idx_q] <= cordic_dout_in;
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
module tb_cordic_scheduler;

    localparam int CH = 4;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst_in = 1'b1;
    logic [CH*DW-1:0]     data_in = '0;
    logic                 valid_in = 1'b0;
    logic                 ready_out;
    logic signed [DW-1:0] data_out [CH];
    logic                 valid_out;
    logic [DW-1:0]        cordic_tdata;
    logic                 cordic_tvalid;
    logic                 cordic_tready = 1'b1;
    logic [DW-1:0]        env_dd;
    logic                 env_dv;
    logic                 cordic_aresetn;
    logic                 busy_out;
    logic                 error_out;

    always #5 clk = ~clk;

    cordic_scheduler #(
        .CHANNELS  (CH),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .data_in             (data_in),
        .valid_in            (valid_in),
        .ready_out           (ready_out),
        .data_out            (data_out),
        .valid_out           (valid_out),
        .cordic_tdata_out    (cordic_tdata),
        .cordic_tvalid_out   (cordic_tvalid),
        .cordic_tready_in    (cordic_tready),
        .cordic_dout_in      (env_dd),
        .cordic_dout_valid_in(env_dv),
        .cordic_aresetn_out  (cordic_aresetn),
        .busy_out            (busy_out),
        .error_out           (error_out)
    );

    // Stand-in CORDIC transform: any fixed per-word function exposes ordering errors.
    function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
        return x * 32'd7 + 32'd5;
    endfunction

    // Environment CORDIC: fixed latency lat, flushed by its own reset.
    int            lat = 3;
    logic [7:0]    pv;
    logic [DW-1:0] pd [8];
    logic          spur = 1'b0;
    logic [DW-1:0] spur_d = '0;

    always @(posedge clk) begin
        if (!cordic_aresetn) begin
            pv <= '0;
        end else begin
            pv[0] <= cordic_tvalid & cordic_tready;
            pd[0] <= f(cordic_tdata);
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign env_dv = pv[lat-1] | spur;
    assign env_dd = spur ? spur_d : pd[lat-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: a frame is outstanding from accept until
    // CH results have come back; the cycle after is the completion pulse.
    bit            m_active = 1'b0;
    bit            m_pulse  = 1'b0;
    bit            m_err    = 1'b0;
    int            m_issued = 0;
    int            m_ret    = 0;
    logic [DW-1:0] m_frame [CH];
    logic [DW-1:0] m_out   [CH];

    // Observation logs, cleared at each frame launch.
    int hs_c[$];
    logic [DW-1:0] hs_d[$];
    int vo_c[$];
    int acc_c[$];
    int arn_low = 0;
    int base = 0;

    initial begin
        for (int i = 0; i < CH; i++) m_out[i] = '0;
        forever begin
            bit rdy;
            bit exp_tv;
            @(negedge clk);
            rdy    = !m_active && !m_pulse;
            exp_tv = m_active && (m_issued < CH);
            if (cyc >= 1) begin
                check("ready_out", ready_out, rdy);
                check("busy_out", busy_out, !rdy);
                check("valid_out", valid_out, m_pulse);
                check("tvalid", cordic_tvalid, exp_tv);
                if (exp_tv) check("tdata", cordic_tdata, m_frame[m_issued]);
                check("error_out", error_out, m_err);
                check("aresetn", cordic_aresetn, !rst_in);
                for (int i = 0; i < CH; i++) check("data_out", $unsigned(data_out[i]), m_out[i]);
            end
            if (cordic_tvalid === 1'b1 && cordic_tready) begin
                hs_c.push_back(cyc);
                hs_d.push_back(cordic_tdata);
            end
            if (valid_out === 1'b1) vo_c.push_back(cyc);
            if (ready_out === 1'b1 && valid_in) acc_c.push_back(cyc);
            if (cordic_aresetn === 1'b0) arn_low++;
            // Advance the reference with this cycle's inputs.
            if (rst_in) begin
                m_active = 1'b0;
                m_pulse  = 1'b0;
                m_err    = 1'b0;
                m_issued = 0;
                m_ret    = 0;
                for (int i = 0; i < CH; i++) m_out[i] = '0;
            end else begin
                m_pulse = 1'b0;
                if (exp_tv && cordic_tready) m_issued++;
                if (env_dv) begin
                    if (m_active) begin
                        m_ret++;
                        if (m_ret == CH) begin
                            m_active = 1'b0;
                            m_pulse  = 1'b1;
                            for (int i = 0; i < CH; i++) m_out[i] = f(m_frame[i]);
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (rdy && valid_in) begin
                    m_active = 1'b1;
                    m_issued = 0;
                    m_ret    = 0;
                    for (int i = 0; i < CH; i++) m_frame[i] = data_in[DW*i +: DW];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w0, w1, w2, w3);
        data_in  = {w3, w2, w1, w0};
        valid_in = 1'b1;
        base     = cyc;
        hs_c.delete();
        hs_d.delete();
        vo_c.delete();
        acc_c.delete();
        arn_low = 0;
    endtask

    task automatic wait_vo(input int maxc, output int rel);
        logic seen;
        seen = 1'b0;
        rel  = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                seen = 1'b1;
                rel  = cyc - base;
                break;
            end
        end
        check("valid_out_seen", seen, 1'b1);
    endtask

    task automatic check_out(input logic [DW-1:0] e0, e1, e2, e3);
        check("out_ch0", $unsigned(data_out[0]), e0);
        check("out_ch1", $unsigned(data_out[1]), e1);
        check("out_ch2", $unsigned(data_out[2]), e2);
        check("out_ch3", $unsigned(data_out[3]), e3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        tick();
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check("rst_ready", ready_out, 1'b1);
        check("rst_valid", valid_out, 1'b0);
        check("rst_error", error_out, 1'b0);
        check("rst_tvalid", cordic_tvalid, 1'b0);
        check("rst_data0", $unsigned(data_out[0]), 32'd0);

        // Basic frame, latency 3, tready held high.
        tick();
        send(1, 2, 3, 4);
        tick();
        valid_in = 1'b0;
        wait_vo(40, rel);
        check("t1_vo_cycle", rel, 8);
        check_out(12, 19, 26, 33);
        check("t1_hs_count", hs_c.size(), 4);
        for (int i = 0; i < hs_c.size() && i < 4; i++) begin
            check("t1_hs_cycle", hs_c[i] - base, i + 1);
            check("t1_hs_data", hs_d[i], i + 1);
        end

        // Backpressure on cycles 2-4.
        tick();
        send(10, 20, 30, 40);
        tick();
        valid_in = 1'b0;
        tick();
        cordic_tready = 1'b0;
        tick();
        tick();
        tick();
        cordic_tready = 1'b1;
        wait_vo(40, rel);
        check("t2_vo_cycle", rel, 11);
        check_out(75, 145, 215, 285);
        check("t2_hs_count", hs_c.size(), 4);
        if (hs_c.size() == 4) begin
            check("t2_hs1", hs_c[1] - base, 5);
            check("t2_hs3", hs_c[3] - base, 7);
            check("t2_hs1_data", hs_d[1], 20);
        end

        // valid_in held across three frames: one accept per frame period.
        tick();
        send(5, 6, 7, 8);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (acc_c.size() >= 3) break;
        end
        tick();
        valid_in = 1'b0;
        wait_vo(40, rel);
        tick();
        check("t3_acc_count", acc_c.size(), 3);
        check("t3_vo_count", vo_c.size(), 3);
        for (int i = 0; i < 3 && i < acc_c.size(); i++)
            check("t3_acc_cycle", acc_c[i] - base, i * (CH + lat + 2));
        for (int i = 0; i < 3 && i < vo_c.size(); i++)
            check("t3_vo_cycle", vo_c[i] - base, CH + lat + 1 + i * (CH + lat + 2));
        check_out(40, 47, 54, 61);

        // Reset for two cycles after the second issue.
        tick();
        send(1, 2, 3, 4);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check("t4_ready_after_rst", ready_out, 1'b1);
        check("t4_aresetn_low_cycles", arn_low, 2);
        repeat (6) tick();
        check("t4_no_valid_out", vo_c.size(), 0);
        send(9, 8, 7, 6);
        tick();
        valid_in = 1'b0;
        wait_vo(40, rel);
        check("t4_vo_cycle", rel, 8);
        check_out(68, 61, 54, 47);

        // Stray CORDIC result while idle.
        tick();
        tick();
        spur   = 1'b1;
        spur_d = 32'hDEAD;
        tick();
        spur = 1'b0;
        @(negedge clk);
        check("t5_error_set", error_out, 1'b1);
        check("t5_data_kept", $unsigned(data_out[0]), 68);
        tick();
        send(1, 2, 3, 4);
        tick();
        valid_in = 1'b0;
        wait_vo(40, rel);
        check("t5_vo_cycle", rel, 8);
        check_out(12, 19, 26, 33);
        check("t5_error_sticky", error_out, 1'b1);
        tick();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check("t5_error_cleared", error_out, 1'b0);

        // Latency 1: collection overlaps issue.
        lat = 1;
        tick();
        send(3, 1, 4, 1);
        tick();
        valid_in = 1'b0;
        wait_vo(40, rel);
        check("t6_vo_cycle", rel, 6);
        check_out(26, 12, 33, 12);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
